// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared minibus types for the RAM slave and its lane aligner
package rv32ima_pkg;

    typedef enum logic [1:0] {
        MB_BYTE = 2'b00,
        MB_HALF = 2'b01,
        MB_WORD = 2'b10,
        MB_RSVD = 2'b11
    } minibus_width_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } minibus_slv_state_t;

    function automatic logic minibus_bad_align(input minibus_width_t width, input logic [1:0] lane);
        case (width)
            MB_BYTE: return 1'b0;
            MB_HALF: return lane[0];
            MB_WORD: return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/minibus_lane_align.sv
// rtl/minibus_lane_align.sv - byte strobes, store replication and load extraction for one 32-bit word
module minibus_lane_align
    import rv32ima_pkg::*;
(
    input  minibus_width_t width,
    input  logic [1:0]     lane,
    input  logic [31:0]    wdata,
    input  logic [31:0]    rword,
    output logic [3:0]     strb,
    output logic [31:0]    wword,
    output logic [31:0]    rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        strb      = 4'b0000;
        wword     = wdata;
        rdata_ext = 32'h0;
        shifted   = rword >> {lane, 3'b000};
        case (width)
            MB_BYTE: begin
                strb      = 4'b0001 << lane;
                wword     = {4{wdata[7:0]}};
                rdata_ext = {24'h0, shifted[7:0]};
            end
            MB_HALF: begin
                strb      = lane[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = {16'h0, shifted[15:0]};
            end
            MB_WORD: begin
                strb      = 4'b1111;
                wword     = wdata;
                rdata_ext = rword;
            end
            default: begin
                strb      = 4'b0000;
                wword     = wdata;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/minibus_ram_slave.sv
// rtl/minibus_ram_slave.sv - word-organised RAM responder on the minibus with programmable wait states
module minibus_ram_slave
    import rv32ima_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_wen,
    input  logic        req_ren,
    input  logic [1:0]  req_width,
    output logic        res_ack,
    output logic        res_error,
    output logic [31:0] res_rdata
);

    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

    logic [31:0] mem [MEM_WORDS];

    minibus_slv_state_t state;
    logic [3:0]         cnt;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    minibus_width_t     cap_width;
    logic               cap_store;
    logic               rst_done;

    // In IDLE with no wait states the access commits on the capture edge, so use the live bus.
    logic           in_idle;
    logic [31:0]    eff_addr;
    logic [31:0]    eff_wdata;
    minibus_width_t eff_width;
    logic           eff_store;

    assign in_idle   = (state == IDLE);
    assign eff_addr  = in_idle ? req_addr : cap_addr;
    assign eff_wdata = in_idle ? req_wdata : cap_wdata;
    assign eff_width = in_idle ? minibus_width_t'(req_width) : cap_width;
    assign eff_store = in_idle ? req_wen : cap_store;

    logic [32:0]      offset;
    logic             in_range;
    logic             acc_err;
    logic [IDX_W-1:0] idx;

    // 33-bit subtraction: an address below ADDR_BASE wraps to a value beyond SPAN.
    assign offset   = {1'b0, eff_addr} - {1'b0, ADDR_BASE};
    assign in_range = offset < SPAN;
    assign acc_err  = !in_range || minibus_bad_align(eff_width, eff_addr[1:0]);
    assign idx      = offset[IDX_W+1:2];

    logic [3:0]  strb;
    logic [31:0] wword;
    logic [31:0] rdata_ext;
    logic [31:0] rword;

    assign rword = mem[idx];

    minibus_lane_align u_align (
        .width     (eff_width),
        .lane      (eff_addr[1:0]),
        .wdata     (eff_wdata),
        .rword     (rword),
        .strb      (strb),
        .wword     (wword),
        .rdata_ext (rdata_ext)
    );

    // rst_done keeps the zero-wait path from committing while nRST is held low.
    logic start;
    logic commit;

    assign start  = in_idle && rst_done && (req_ren || req_wen);
    assign commit = (start && (WAIT_STATES == 0)) || (state == WAIT && cnt == 4'd0);

    always_ff @(posedge CLK) begin
        if (commit && eff_store && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
            cap_width <= MB_BYTE;
            cap_store <= 1'b0;
            rst_done  <= 1'b0;
            res_ack   <= 1'b0;
            res_error <= 1'b0;
            res_rdata <= 32'h0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_width <= minibus_width_t'(req_width);
                        cap_store <= req_wen;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                res_ack   <= 1'b1;
                res_error <= acc_err;
                res_rdata <= (acc_err || eff_store) ? 32'h0 : rdata_ext;
            end else begin
                res_ack   <= 1'b0;
                res_error <= 1'b0;
                res_rdata <= 32'h0;
            end
        end
    end

endmodule
